// File: rtl/controlador_vedacao.sv
// Bottling/sealing station sequencer: conveyor, fill valve and sealing actuator,
// gated on cork availability, with a saturating sealed-bottle count.
module controlador_vedacao #(
    parameter logic [25:0] TEMPO_VEDACAO        = 26'd25000000,
    parameter logic [27:0] TEMPO_MAX_ENCHIMENTO = 28'd150000000,
    parameter logic [6:0]  MAX_GARRAFAS         = 7'd99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_liga,
    input  logic       sensor_garrafa,
    input  logic       sensor_nivel,
    input  logic       alarme_rolha_vazia,
    input  logic       dispensador_ativo,
    input  logic       btn_limpa_erro,
    output logic       motor_esteira,
    output logic       valvula_enchimento,
    output logic       vedador_ativo,
    output logic       vedacao_concluida,
    output logic       erro_enchimento,
    output logic [6:0] garrafas_vedadas,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        AVANCA        = 3'd1,
        ENCHE         = 3'd2,
        AGUARDA_ROLHA = 3'd3,
        VEDA          = 3'd4,
        CONCLUI       = 3'd5,
        LIBERA        = 3'd6,
        ERRO          = 3'd7
    } estado_t;

    localparam logic [27:0] FIM_VEDACAO    = {2'b00, TEMPO_VEDACAO} - 28'd1;
    localparam logic [27:0] FIM_ENCHIMENTO = TEMPO_MAX_ENCHIMENTO - 28'd1;

    estado_t     atual;
    estado_t     proximo;
    logic [27:0] timer;
    logic        btn_anterior;
    logic        borda_btn;

    assign borda_btn = btn_limpa_erro & ~btn_anterior;
    assign estado    = atual;

    always_comb begin
        proximo = atual;
        case (atual)
            IDLE:          if (sw_liga) proximo = AVANCA;
            AVANCA: begin
                if (sensor_garrafa)  proximo = ENCHE;
                else if (!sw_liga)   proximo = IDLE;
            end
            // level sensor takes priority over a timeout landing on the same cycle
            ENCHE: begin
                if (sensor_nivel)                 proximo = AGUARDA_ROLHA;
                else if (timer == FIM_ENCHIMENTO) proximo = ERRO;
            end
            AGUARDA_ROLHA: if (!alarme_rolha_vazia && !dispensador_ativo) proximo = VEDA;
            VEDA:          if (timer == FIM_VEDACAO) proximo = CONCLUI;
            CONCLUI:       proximo = LIBERA;
            LIBERA:        if (!sensor_garrafa) proximo = sw_liga ? AVANCA : IDLE;
            ERRO:          if (borda_btn) proximo = LIBERA;
        endcase
    end

    // Outputs decode the next state so they line up with the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            atual              <= IDLE;
            timer              <= '0;
            btn_anterior       <= 1'b0;
            motor_esteira      <= 1'b0;
            valvula_enchimento <= 1'b0;
            vedador_ativo      <= 1'b0;
            vedacao_concluida  <= 1'b0;
            erro_enchimento    <= 1'b0;
            garrafas_vedadas   <= '0;
        end else begin
            atual        <= proximo;
            btn_anterior <= btn_limpa_erro;
            if (proximo != atual)
                timer <= '0;
            else if (atual == ENCHE || atual == VEDA)
                timer <= timer + 28'd1;
            motor_esteira      <= (proximo == AVANCA) || (proximo == LIBERA);
            valvula_enchimento <= (proximo == ENCHE);
            vedador_ativo      <= (proximo == VEDA);
            vedacao_concluida  <= (proximo == CONCLUI);
            erro_enchimento    <= (proximo == ERRO);
            if (proximo == CONCLUI && garrafas_vedadas != MAX_GARRAFAS)
                garrafas_vedadas <= garrafas_vedadas + 7'd1;
        end
    end

endmodule

// File: tb/tb_controlador_vedacao.sv
// Randomized bench for controlador_vedacao: per-bottle expectations are queued by
// the driver and matched by a monitor each time the station releases a bottle.
module tb_controlador_vedacao;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sw_liga = 1'b0;
    logic       sensor_garrafa = 1'b0;
    logic       sensor_nivel = 1'b0;
    logic       alarme = 1'b0;
    logic       disp = 1'b0;
    logic       btn = 1'b0;
    logic       motor_esteira;
    logic       valvula_enchimento;
    logic       vedador_ativo;
    logic       vedacao_concluida;
    logic       erro_enchimento;
    logic [6:0] garrafas_vedadas;
    logic [2:0] estado;

    controlador_vedacao #(
        .TEMPO_VEDACAO       (26'd4),
        .TEMPO_MAX_ENCHIMENTO(28'd10),
        .MAX_GARRAFAS        (7'd99)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .sw_liga           (sw_liga),
        .sensor_garrafa    (sensor_garrafa),
        .sensor_nivel      (sensor_nivel),
        .alarme_rolha_vazia(alarme),
        .dispensador_ativo (disp),
        .btn_limpa_erro    (btn),
        .motor_esteira     (motor_esteira),
        .valvula_enchimento(valvula_enchimento),
        .vedador_ativo     (vedador_ativo),
        .vedacao_concluida (vedacao_concluida),
        .erro_enchimento   (erro_enchimento),
        .garrafas_vedadas  (garrafas_vedadas),
        .estado            (estado)
    );

    always #5 clk = ~clk;

    typedef struct {
        int valve;
        int seal;
        int pulse;
        int wait_c;
        int erro_c;
        int count;
        int next;
    } esp_t;

    esp_t fila[$];
    int   errors = 0;
    int   checks = 0;
    int   selados = 0;
    int   pulsos_total = 0;

    task automatic chk(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic sinal(input int sel);
        case (sel)
            0:       return valvula_enchimento;
            1:       return vedador_ativo;
            2:       return motor_esteira;
            default: return (estado == 3'd1);
        endcase
    endfunction

    task automatic esperar(input int sel, input logic val, input string nome);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sinal(sel) == val) return;
        end
        errors++;
        checks++;
        $display("FAIL timeout %s: signal never reached %0b within 40 cycles", nome, val);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "aborting after timeout");
    endtask

    // Expected outcome per bottle, from the station rules: fill lasts f cycles or
    // times out at 10, seal lasts 4, cork wait lasts every blocked cycle plus one.
    task automatic garrafa(input int a, input int f, input int w1, input int w2,
                           input int h, input int l, input bit held,
                           input bit mid_disp, input bit sw_stop);
        esp_t e;
        bit   ok;
        ok = (f <= 10);
        if (ok) selados++;
        e.valve  = ok ? f : 10;
        e.seal   = ok ? 4 : 0;
        e.pulse  = ok ? 1 : 0;
        e.wait_c = ok ? (w1 + w2 + 1) : 0;
        e.erro_c = ok ? 0 : (h + 2);
        e.count  = (selados > 99) ? 99 : selados;
        e.next   = sw_stop ? 0 : 1;
        fila.push_back(e);

        sw_liga = 1'b1;
        esperar(3, 1'b1, "avanca");
        repeat (a - 1) @(negedge clk);
        sensor_garrafa = 1'b1;
        if (held) btn = 1'b1;
        esperar(0, 1'b1, "valvula_liga");
        if (ok) begin
            repeat (f - 1) @(negedge clk);
            sensor_nivel = 1'b1;
            esperar(0, 1'b0, "valvula_desliga");
            sensor_nivel = 1'b0;
            btn = 1'b0;
            if (w1 > 0) begin
                alarme = 1'b1;
                repeat (w1) @(negedge clk);
                alarme = 1'b0;
            end
            if (w2 > 0) begin
                disp = 1'b1;
                repeat (w2) @(negedge clk);
                disp = 1'b0;
            end
            esperar(1, 1'b1, "vedador_liga");
            if (mid_disp) disp = 1'b1;
            if (sw_stop) sw_liga = 1'b0;
            esperar(1, 1'b0, "vedador_desliga");
            disp = 1'b0;
        end else begin
            esperar(0, 1'b0, "valvula_timeout");
            repeat (h) @(negedge clk);
            btn = 1'b0;
            @(negedge clk);
            btn = 1'b1;
        end
        esperar(2, 1'b1, "libera");
        btn = 1'b0;
        if (sw_stop) sw_liga = 1'b0;
        repeat (l) @(negedge clk);
        sensor_garrafa = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: accumulates what the DUT shows per bottle, checks on leaving LIBERA.
    initial begin
        int   n_valve, n_seal, n_pulse, n_wait, n_erro, prev;
        bit   pulse_prev, dobro, act_wait;
        esp_t e;
        n_valve = 0; n_seal = 0; n_pulse = 0; n_wait = 0; n_erro = 0; prev = 0;
        pulse_prev = 0; dobro = 0; act_wait = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                n_valve = 0; n_seal = 0; n_pulse = 0; n_wait = 0; n_erro = 0;
                prev = 0; pulse_prev = 0; dobro = 0; act_wait = 0;
            end else begin
                if (prev == 6 && int'(estado) != 6) begin
                    if (fila.size() == 0) begin
                        chk("fila_vazia", 1, 0);
                    end else begin
                        e = fila.pop_front();
                        chk("valvula_ciclos", n_valve, e.valve);
                        chk("vedador_ciclos", n_seal, e.seal);
                        chk("pulsos", n_pulse, e.pulse);
                        chk("espera_rolha", n_wait, e.wait_c);
                        chk("atuador_na_espera", int'(act_wait), 0);
                        chk("erro_ciclos", n_erro, e.erro_c);
                        chk("garrafas", int'(garrafas_vedadas), e.count);
                        chk("estado_apos_libera", int'(estado), e.next);
                        chk("motor_apos_libera", int'(motor_esteira), (e.next == 1) ? 1 : 0);
                        chk("pulso_duplo", int'(dobro), 0);
                    end
                    n_valve = 0; n_seal = 0; n_pulse = 0; n_wait = 0; n_erro = 0;
                    dobro = 0; act_wait = 0;
                end
                if (valvula_enchimento) n_valve++;
                if (vedador_ativo) n_seal++;
                if (vedacao_concluida) begin
                    n_pulse++;
                    pulsos_total++;
                    if (pulse_prev) dobro = 1;
                end
                if (estado == 3'd3) begin
                    n_wait++;
                    if (motor_esteira | valvula_enchimento | vedador_ativo) act_wait = 1;
                end
                if (erro_enchimento) n_erro++;
                pulse_prev = vedacao_concluida;
                prev = int'(estado);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        sw_liga = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_estado", int'(estado), 0);
        chk("reset_motor", int'(motor_esteira), 0);
        chk("reset_garrafas", int'(garrafas_vedadas), 0);
        chk("reset_saidas", int'({valvula_enchimento, vedador_ativo, vedacao_concluida, erro_enchimento}), 0);
        reset = 1'b1;

        // Line switched off in AVANCA with no bottle returns to IDLE next cycle.
        esperar(3, 1'b1, "avanca_inicial");
        chk("avanca_motor", int'(motor_esteira), 1);
        sw_liga = 1'b0;
        @(negedge clk);
        chk("avanca_para_idle", int'(estado), 0);
        chk("idle_motor", int'(motor_esteira), 0);

        garrafa(3, 5, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0);
        garrafa(2, 4, 20, 3, 0, 2, 1'b0, 1'b0, 1'b0);
        garrafa(1, 11, 0, 0, 3, 2, 1'b1, 1'b0, 1'b0);
        garrafa(1, 11, 0, 0, 0, 1, 1'b0, 1'b0, 1'b0);
        garrafa(2, 6, 1, 0, 0, 2, 1'b0, 1'b1, 1'b1);
        garrafa(1, 10, 0, 2, 0, 1, 1'b1, 1'b0, 1'b0);

        while (selados < 100) begin
            int f;
            f = ($urandom_range(7, 0) == 0) ? 11 : int'($urandom_range(10, 1));
            garrafa(int'($urandom_range(3, 1)), f, int'($urandom_range(4, 0)),
                    int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                    int'($urandom_range(3, 1)), 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), ($urandom_range(5, 0) == 0));
        end
        repeat (2) @(negedge clk);
        chk("fila_pendente", fila.size(), 0);
        chk("total_pulsos", pulsos_total, selados);
        chk("saturacao", int'(garrafas_vedadas), 99);

        // Asynchronous reset in the middle of a seal.
        sw_liga = 1'b1;
        esperar(3, 1'b1, "avanca_final");
        sensor_garrafa = 1'b1;
        esperar(0, 1'b1, "valvula_final");
        sensor_nivel = 1'b1;
        esperar(0, 1'b0, "valvula_final_off");
        sensor_nivel = 1'b0;
        esperar(1, 1'b1, "vedador_final");
        #2 reset = 1'b0;
        #1;
        chk("areset_estado", int'(estado), 0);
        chk("areset_vedador", int'(vedador_ativo), 0);
        chk("areset_garrafas", int'(garrafas_vedadas), 0);
        chk("areset_saidas", int'({motor_esteira, valvula_enchimento, vedacao_concluida, erro_enchimento}), 0);
        sensor_garrafa = 1'b0;
        sw_liga = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("pos_reset_pulsos", pulsos_total, selados);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
